sound_arbiter: RTL and testbench
================================

Name: sound_arbiter

Overview:
- Shares the single speaker tone generator between several game sound events (food eaten, game over, game start, level up).
- Latches one-cycle event requests and picks one by fixed priority.
- Plays the chosen event's multi-note tune from a constant table by driving the tone generator's freq input. Instantiated once in the top level between the game FSM and freqgen.

Parameters:
- NUM_REQ, 4, number of requesters; request index = tune ID; higher index = higher priority.
- NOTES_PER_TUNE, 3, notes per tune.
- NOTE_CYCLES, 3_000_000, clk cycles per note (60 ms at 50 MHz); the bench overrides it to 4.
- CNT_W, 32, width of the note-duration counter.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  one-cycle event pulses; bit i requests tune i.
- mute  in  1  forces freq to 0; sequencing continues.
- freq  out  32  note frequency in Hz to freqgen; 0 = silent.
- busy  out  1  high while a tune is playing.
- active_id  out  $clog2(NUM_REQ)  ID of the playing tune; 0 when idle.
- done  out  1  one-cycle pulse when a tune finishes its last note.

Behaviour:
- Reset (async, reset_n low): state IDLE; pending=0; freq=0; busy=0; active_id=0; done=0; note index and counter = 0. Reset mid-tune aborts immediately with no done pulse.
- Pending latch: pending[i] is set at any edge where req[i]=1. It is cleared at the edge where tune i is granted. If req[i] arrives on its own grant edge, the set wins, so the tune replays once after the current play. Depth is one: repeated requests while pending merge into one.
- Arbitration: the grant goes to the highest set bit of pending. Only bits already registered in pending are considered, so a req has 1 cycle of latch latency.
- States (enum in package): IDLE, PLAY, DONE.
- IDLE: freq=0, busy=0.
  - If pending != 0, grant the highest bit; at that edge: state to PLAY, active_id=ID, note index=0, counter=0, freq=TUNE_TABLE[ID][0], busy=1.
  - Latency: req pulse at edge k; freq valid after edge k+1.
- PLAY: counter increments each cycle.
  - When counter = NOTE_CYCLES-1: counter returns to 0 and note index increments; freq loads the next table note on that same edge.
  - Each note therefore lasts exactly NOTE_CYCLES cycles.
  - After the last note expires: state to DONE, freq=0.
- DONE: done=1 for exactly one cycle, busy=0, active_id returns to 0, then IDLE. There is always at least one silent cycle between tunes.
- Table entries of 0 are timed rests; they are still counted.
- mute: the freq output is ANDed with ~mute combinationally after the freq register. Counters, busy and done are unaffected.
- The counter never exceeds NOTE_CYCLES-1. Widths are unsigned; the note index is $clog2(NOTES_PER_TUNE) bits and does not wrap within a tune.

Optional Feature:
- Macro: SOUND_ARB_PREEMPT_EN.
- Defined: in PLAY, if pending holds a bit higher than active_id, preemption occurs at the next edge. The new tune starts at note 0 with counter=0 and its pending bit is cleared. The preempted tune is dropped: no done pulse and it is not re-queued.
- Undefined: a tune always plays to completion. Higher requests wait in pending.

Decomposition:
- Package sound_pkg holds:
  - the state_t enum;
  - the tune_id_t typedef;
  - the localparam TUNE_TABLE [NUM_REQ][NOTES_PER_TUNE] of 32-bit Hz values: ID0 food {262,349,491}, ID1 start {262,330,392}, ID2 level {392,491,523}, ID3 game over {491,349,262}.
- One natural sub-module, note_timer:
  - a counter with a start/clear input;
  - parameter NOTE_CYCLES;
  - a one-cycle tick output at NOTE_CYCLES-1.

Test Plan:
- Single request: NOTE_CYCLES=4, req=4'b0001 for 1 cycle → freq 262/349/491 for 4 cycles each, starting 2 edges after the pulse. Then done=1 for 1 cycle, busy=0, freq=0.
- Simultaneous requests: req=4'b1001 in one cycle → game-over tune {491,349,262} plays first with active_id=3. After its done, 1 idle cycle, then the food tune plays.
- No preemption (macro undefined): req[3] pulsed during note 1 of the food tune → food tune completes, then game-over starts. Macro defined: the edge after latch shows freq=491, active_id=3, and no done pulse for food.
- Request merging and replay: req[0] pulsed 3 times during food playback → food tune plays exactly once more. A req[0] on its own grant edge → exactly one replay.
- Mute: mute=1 mid-tune → freq=0 immediately while busy stays 1. Done timing is unchanged (3×4 cycles total).
- Reset mid-tune: reset_n low for 1 ns during note 2 → freq, busy, active_id and pending clear asynchronously with no done pulse. After release, the block stays IDLE until a new req.

Source files
------------

// File: rtl/sound_pkg.sv
// sound_pkg: shared types, tune table and helpers for the sound arbiter.
//   state_t     : arbiter FSM states (IDLE, PLAY, DONE)
//   tune_id_t   : tune / requester index
//   TUNE_TABLE  : per-tune note frequencies in Hz, 0 = timed rest
//   highest_req : index of the highest set request bit (fixed priority)
package sound_pkg;

  localparam int TUNE_COUNT = 4;
  localparam int TUNE_LEN   = 3;
  localparam int ID_W       = $clog2(TUNE_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [ID_W-1:0] tune_id_t;

  // ID0 food, ID1 start, ID2 level up, ID3 game over.
  localparam logic [31:0] TUNE_TABLE [TUNE_COUNT][TUNE_LEN] = '{
    '{32'd262, 32'd349, 32'd491},
    '{32'd262, 32'd330, 32'd392},
    '{32'd392, 32'd491, 32'd523},
    '{32'd491, 32'd349, 32'd262}
  };

  // Higher index wins, so the last set bit found in an upward scan is kept.
  function automatic tune_id_t highest_req(input logic [TUNE_COUNT-1:0] bits);
    tune_id_t id;
    id = '0;
    for (int i = 0; i < TUNE_COUNT; i++) begin
      if (bits[i]) id = tune_id_t'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/sound_arbiter_note_timer.sv
// note_timer: note-duration counter.
//   clk, reset_n : clock, async active-low reset
//   start        : clears the counter to 0 (new tune begins)
//   en           : count enable (high while a tune plays)
//   tick         : one-cycle pulse when the counter sits at NOTE_CYCLES-1;
//                  the counter wraps to 0 on that same edge
module note_timer #(
  parameter int NOTE_CYCLES = 3_000_000,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NOTE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // start overrides a coincident tick: a freshly started note is never expiring.
  assign tick = en && !start && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sound_arbiter.sv
// sound_arbiter: shares the speaker tone generator between game sound events.
// One-cycle requests are latched into a pending vector, the highest pending
// index is granted, and that tune's notes are played from TUNE_TABLE.
//   clk, reset_n : clock, async active-low reset
//   req          : one-cycle event pulses, bit i requests tune i
//   mute         : forces freq to 0 without disturbing sequencing
//   freq         : note frequency in Hz, 0 = silent
//   busy         : high while a tune plays
//   active_id    : playing tune ID, 0 when idle
//   done         : one-cycle pulse after the last note of a tune
// Build option: define SOUND_ARB_PREEMPT_EN to let a higher pending request
// abort the playing tune (no done pulse, aborted tune is not re-queued).
// Without it every tune plays to completion.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int NOTES_PER_TUNE = 3,
  parameter int NOTE_CYCLES    = 3_000_000,
  parameter int CNT_W          = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       mute,
  output logic [31:0]                freq,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       done
);

  localparam int NI_W = $clog2(NOTES_PER_TUNE);
  localparam logic [NI_W-1:0] LAST_NOTE = NI_W'(NOTES_PER_TUNE - 1);

  state_t            state, state_next;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] grant_mask;
  logic [31:0]       freq_q;
  tune_id_t          active_q;
  tune_id_t          top_id;
  logic [NI_W-1:0]   note_idx;
  logic [NI_W-1:0]   note_next;
  logic              any_pending;
  logic              preempt;
  logic              grant;
  logic              tick;
  logic              last_note;
  logic              timer_en;

  assign any_pending = |pending;
  assign top_id      = highest_req(pending);
  assign last_note   = (note_idx == LAST_NOTE);
  assign note_next   = note_idx + 1'b1;

`ifdef SOUND_ARB_PREEMPT_EN
  assign preempt = (state == PLAY) && any_pending && (top_id > active_q);
`else
  assign preempt = 1'b0;
`endif

  // Arbitration only looks at registered pending bits, never at raw req.
  assign grant      = ((state == IDLE) && any_pending) || preempt;
  assign grant_mask = grant ? (NUM_REQ'(1) << top_id) : '0;

  note_timer #(
    .NOTE_CYCLES (NOTE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_note_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (grant),
    .en      (timer_en),
    .tick    (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_pending) state_next = PLAY;
      PLAY: begin
        if (preempt)                state_next = PLAY;
        else if (tick && last_note) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    timer_en = 1'b0;
    case (state)
      PLAY: begin
        busy     = 1'b1;
        timer_en = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Pending latch: a req on its own grant edge re-arms the bit (set wins).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= (pending & ~grant_mask) | req;
  end

  // Note sequencing and the registered frequency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_q   <= '0;
      active_q <= '0;
      note_idx <= '0;
    end else if (grant) begin
      freq_q   <= TUNE_TABLE[top_id][0];
      active_q <= top_id;
      note_idx <= '0;
    end else if ((state == PLAY) && tick) begin
      if (last_note) begin
        freq_q   <= '0;
        active_q <= '0;
        note_idx <= '0;
      end else begin
        freq_q   <= TUNE_TABLE[active_q][note_next];
        note_idx <= note_next;
      end
    end
  end

  assign freq      = freq_q & {32{~mute}};
  assign active_id = active_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: directed bench for sound_arbiter with NOTE_CYCLES = 4.
module tb_sound_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic        mute;
  logic [31:0] freq;
  logic        busy;
  logic [1:0]  active_id;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  sound_arbiter #(
    .NUM_REQ        (4),
    .NOTES_PER_TUNE (3),
    .NOTE_CYCLES    (4),
    .CNT_W          (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .mute      (mute),
    .freq      (freq),
    .busy      (busy),
    .active_id (active_id),
    .done      (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Hand-written expected tunes.
  function automatic logic [31:0] exp_note(input int id, input int n);
    logic [31:0] t [4][3];
    t = '{'{32'd262, 32'd349, 32'd491},
          '{32'd262, 32'd330, 32'd392},
          '{32'd392, 32'd491, 32'd523},
          '{32'd491, 32'd349, 32'd262}};
    return t[id][n];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] f, input logic b,
                           input logic [1:0] id, input logic d);
    check({tag, "_freq"}, freq, f);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, "_id"}, {30'd0, active_id}, {30'd0, id});
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
  endtask

  // Entered just after the grant edge; checks all 12 note cycles, then the
  // DONE cycle. pulse is driven on req during cycles flagged in pulse_cyc;
  // mute is held high for cycles in [mute_lo, mute_hi).
  task automatic play_tune(input int id, input int mute_lo, input int mute_hi,
                           input logic [3:0] pulse, input logic [11:0] pulse_cyc);
    logic [1:0] id2;
    id2 = id[1:0];
    for (int c = 0; c < 12; c++) begin
      req  = pulse_cyc[c] ? pulse : 4'b0000;
      mute = (c >= mute_lo) && (c < mute_hi);
      #1;
      check_out($sformatf("t%0d_c%0d", id, c), mute ? 32'd0 : exp_note(id, c / 4),
                1'b1, id2, 1'b0);
      step();
    end
    req  = 4'b0000;
    mute = 1'b0;
    check_out($sformatf("t%0d_done", id), 32'd0, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic start_tune(input logic [3:0] r);
    req = r;
    step();
    req = 4'b0000;
    check_out("latch_wait", 32'd0, 1'b0, 2'd0, 1'b0);
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 4'b0000;
    mute    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("in_reset", 32'd0, 1'b0, 2'd0, 1'b0);
    reset_n = 1'b1;
    step();
    check_out("after_reset", 32'd0, 1'b0, 2'd0, 1'b0);

    // Single request: food tune.
    start_tune(4'b0001);
    play_tune(0, 99, 99, 4'b0000, 12'd0);
    step();
    check_out("single_idle", 32'd0, 1'b0, 2'd0, 1'b0);

    // Simultaneous requests: game over first, then food after one idle cycle.
    start_tune(4'b1001);
    play_tune(3, 99, 99, 4'b0000, 12'd0);
    step();
    check_out("simul_gap", 32'd0, 1'b0, 2'd0, 1'b0);
    step();
    play_tune(0, 99, 99, 4'b0000, 12'd0);
    step();
    check_out("simul_idle", 32'd0, 1'b0, 2'd0, 1'b0);

    // Higher request during note 1 of the food tune.
    start_tune(4'b0001);
`ifdef SOUND_ARB_PREEMPT_EN
    for (int c = 0; c < 6; c++) begin
      req = (c == 4) ? 4'b1000 : 4'b0000;
      check_out($sformatf("pre_food_c%0d", c), exp_note(0, c / 4), 1'b1, 2'd0, 1'b0);
      step();
    end
    req = 4'b0000;
    play_tune(3, 99, 99, 4'b0000, 12'd0);
`else
    play_tune(0, 99, 99, 4'b1000, 12'b0000_0001_0000);
    step();
    check_out("nopre_gap", 32'd0, 1'b0, 2'd0, 1'b0);
    step();
    play_tune(3, 99, 99, 4'b0000, 12'd0);
`endif
    step();
    check_out("pre_idle", 32'd0, 1'b0, 2'd0, 1'b0);

    // Three requests during playback merge into a single replay.
    start_tune(4'b0001);
    play_tune(0, 99, 99, 4'b0001, 12'b0000_0010_1010);
    step();
    check_out("merge_gap", 32'd0, 1'b0, 2'd0, 1'b0);
    step();
    play_tune(0, 99, 99, 4'b0000, 12'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check_out($sformatf("merge_idle%0d", c), 32'd0, 1'b0, 2'd0, 1'b0);
    end

    // Request on its own grant edge: exactly one replay.
    req = 4'b0001;
    step();
    step();
    req = 4'b0000;
    play_tune(0, 99, 99, 4'b0000, 12'd0);
    step();
    check_out("grant_edge_gap", 32'd0, 1'b0, 2'd0, 1'b0);
    step();
    play_tune(0, 99, 99, 4'b0000, 12'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check_out($sformatf("grant_edge_idle%0d", c), 32'd0, 1'b0, 2'd0, 1'b0);
    end

    // Mute over note 1 of the level-up tune; done timing unchanged.
    start_tune(4'b0100);
    play_tune(2, 4, 8, 4'b0000, 12'd0);
    step();
    check_out("mute_idle", 32'd0, 1'b0, 2'd0, 1'b0);

    // Reset during note 2, with a level-up request pending.
    start_tune(4'b0001);
    for (int c = 0; c < 9; c++) begin
      req = (c == 2) ? 4'b0100 : 4'b0000;
      check_out($sformatf("rst_c%0d", c), exp_note(0, c / 4), 1'b1, 2'd0, 1'b0);
      step();
    end
    req = 4'b0000;
    #1;
    reset_n = 1'b0;
    #1;
    check_out("rst_async", 32'd0, 1'b0, 2'd0, 1'b0);
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check_out($sformatf("rst_idle%0d", c), 32'd0, 1'b0, 2'd0, 1'b0);
    end

    // New request after reset plays normally.
    start_tune(4'b0010);
    play_tune(1, 99, 99, 4'b0000, 12'd0);
    step();
    check_out("final_idle", 32'd0, 1'b0, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
